// File: rtl/shift_add_multiplier_param.sv
// Parametrised radix-2 shift-add sequential multiplier.
// Accepts an operation on start while ready and handles signed or unsigned operands.
// Optionally stops early once the remaining multiplier bits are all zero.
// Presents the product and the CALC-cycle count with a one-cycle done pulse.
module shift_add_multiplier_param #(
  parameter int L_WORD     = 8,
  parameter bit EARLY_TERM = 1'b1,
  parameter int IW         = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  signed_mode_i,
  input  logic [L_WORD-1:0]     word1_i,
  input  logic [L_WORD-1:0]     word2_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*L_WORD-1:0]   product_o,
  output logic [IW-1:0]         iterations_o
);

  localparam int PW = 2 * L_WORD;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [L_WORD-1:0] mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     product_q, product_d;
  logic [IW-1:0]     iter_q, iter_d;

  logic [L_WORD-1:0] mag1, mag2;
  logic [IW-1:0]     cnt_inc;
  logic              last_step;

  // State and datapath registers; a synchronous reset clears everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      iter_q    <= iter_d;
    end
  end

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    iter_d    = iter_q;

    // Magnitudes: the most negative value maps onto its unsigned bit pattern.
    mag1 = word1_i;
    mag2 = word2_i;
    if (signed_mode_i && word1_i[L_WORD-1]) mag1 = -word1_i;
    if (signed_mode_i && word2_i[L_WORD-1]) mag2 = -word2_i;

    cnt_inc   = cnt_q + 1'b1;
    last_step = (cnt_inc == IW'(L_WORD)) ||
                (EARLY_TERM && ((mplier_q >> 1) == '0));

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = {{L_WORD{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = signed_mode_i & (word1_i[L_WORD-1] ^ word2_i[L_WORD-1]);
          if ((word1_i == '0) || (word2_i == '0)) begin
            product_d = '0;
            iter_d    = '0;
            state_d   = S_DONE;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_inc;
        if (last_step) state_d = S_FIX;
      end
      S_FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        iter_d    = cnt_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o      = (state_q == S_IDLE);
  assign busy_o       = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o       = (state_q == S_DONE);
  assign product_o    = product_q;
  assign iterations_o = iter_q;

endmodule
